// File: rtl/restoring_divider4b.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : restoring_divider4b                                      |
// | Description : Sequential restoring divider. Each RUN cycle does one    |
// |               shift plus a trial subtract on the shared two's          |
// |               complement add/sub datapath (B ^ Ctrl, cin = Ctrl).      |
// |               Divide-by-zero skips iterating and returns all ones.     |
// |               Optional macro SIGNED_DIV_EN: two's complement operands  |
// |               (magnitudes on accept, sign fix-up on the write edge).   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module restoring_divider4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             done_q, dz_q;
  // Divide-by-zero accepted last edge; results are written on the following edge.
  logic             dz_pend_q;

  logic             w_accept, w_dvs_zero;
  logic [WIDTH:0]   w_p_shift, w_b, w_t, w_p_next;
  logic [WIDTH-1:0] w_q_shift, w_q_next;
  logic             w_ctrl;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH-1:0] w_quot_fin, w_rem_fin, w_dz_rem;

  assign w_accept   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign w_dvs_zero = (divisor_i == '0);

  // Shift P:Q left one place, then trial-subtract D as P' + ~{0,D} + 1.
  assign w_ctrl    = 1'b1;
  assign w_p_shift = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign w_q_shift = {q_q[WIDTH-2:0], 1'b0};
  assign w_b       = {1'b0, d_q} ^ {(WIDTH+1){w_ctrl}};
  assign w_t       = w_p_shift + w_b + {{WIDTH{1'b0}}, w_ctrl};
  // Negative trial result means D did not fit: restore P and shift in a 0.
  assign w_p_next  = w_t[WIDTH] ? w_p_shift : w_t;
  assign w_q_next  = {w_q_shift[WIDTH-1:1], ~w_t[WIDTH]};

`ifdef SIGNED_DIV_EN
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] dvd_raw_q;

  assign w_dvd_mag  = dividend_i[WIDTH-1] ? (-dividend_i) : dividend_i;
  assign w_dvs_mag  = divisor_i[WIDTH-1]  ? (-divisor_i)  : divisor_i;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_quot_fin = neg_q_q ? (-w_q_next) : w_q_next;
  assign w_rem_fin  = neg_r_q ? (-w_p_next[WIDTH-1:0]) : w_p_next[WIDTH-1:0];
  assign w_dz_rem   = dvd_raw_q;

  // Sign bookkeeping captured alongside the operand magnitudes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      dvd_raw_q <= '0;
    end else if (w_accept) begin
      neg_q_q   <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
      neg_r_q   <= dividend_i[WIDTH-1];
      dvd_raw_q <= dividend_i;
    end
  end
`else
  assign w_dvd_mag  = dividend_i;
  assign w_dvs_mag  = divisor_i;
  assign w_quot_fin = w_q_next;
  assign w_rem_fin  = w_p_next[WIDTH-1:0];
  // No iterations ran, so Q still holds the captured dividend.
  assign w_dz_rem   = q_q;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE and DONE share the accept rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) state_d = w_dvs_zero ? S_DONE : S_RUN;
        else         state_d = S_IDLE;
      end
      S_RUN:   if (cnt_q == C_LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy_o = (state_q == S_RUN);
  end

  // Datapath: operand capture, iteration, and result write-back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      dz_pend_q <= 1'b0;
      if (state_q == S_RUN) begin
        p_q   <= w_p_next;
        q_q   <= w_q_next;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          quot_q <= w_quot_fin;
          rem_q  <= w_rem_fin;
          done_q <= 1'b1;
        end
      end
      if (w_accept) begin
        p_q       <= '0;
        q_q       <= w_dvd_mag;
        d_q       <= w_dvs_mag;
        cnt_q     <= '0;
        dz_q      <= 1'b0;
        dz_pend_q <= w_dvs_zero;
      end
      // A pending divide-by-zero completes even if a new request is accepted now.
      if (dz_pend_q) begin
        quot_q <= '1;
        rem_q  <= w_dz_rem;
        dz_q   <= 1'b1;
        done_q <= 1'b1;
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule
`default_nettype wire
